// File: rtl/relprime_pkg.sv
// Shared types for the sequential relatively-prime search controller.
// State encoding and its width are kept here so the FSM and its users agree.
package relprime_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      SUB   = 3'd2,
      CHECK = 3'd3,
      DONE  = 3'd4,
      ERR   = 3'd5
   } state_t;

endpackage

// File: rtl/relprime_ctrl_seq_gcd_sub_step.sv
// One subtractive-GCD step: subtract the smaller operand from the larger.
// eq flags that both operands match, i.e. the GCD has been reached.
module gcd_sub_step #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] a1,
   output logic [WIDTH-1:0] a0_nxt,
   output logic [WIDTH-1:0] a1_nxt,
   output logic             eq
);

   always_comb begin
      eq     = (a0 == a1);
      a0_nxt = a0;
      a1_nxt = a1;
      if (a0 > a1)
         a0_nxt = a0 - a1;
      else if (a1 > a0)
         a1_nxt = a1 - a0;
   end

endmodule

// File: rtl/relprime_ctrl_seq.sv
// Finds the smallest m >= M_START with gcd(n, m) == 1 via subtractive GCD.
// Optional busy-cycle counter output enabled by RELPRIME_CYCLE_COUNT_EN.
module relprime_ctrl_seq
   import relprime_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int M_START = 2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   input  logic [WIDTH-1:0] n_in,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [WIDTH-1:0] result
`ifdef RELPRIME_CYCLE_COUNT_EN
   ,
   output logic [31:0]      cycles
`endif
);

   localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
   localparam logic [WIDTH-1:0] M_INIT = WIDTH'(M_START);

   state_t           state;
   state_t           next_state;
   logic [WIDTH-1:0] n_reg;
   logic [WIDTH-1:0] m_reg;
   logic [WIDTH-1:0] a0;
   logic [WIDTH-1:0] a1;
   logic [WIDTH-1:0] a0_nxt;
   logic [WIDTH-1:0] a1_nxt;
   logic             eq;
   logic             error_q;
   logic [WIDTH-1:0] result_q;

   gcd_sub_step #(.WIDTH(WIDTH)) u_step (
      .a0     (a0),
      .a1     (a1),
      .a0_nxt (a0_nxt),
      .a1_nxt (a1_nxt),
      .eq     (eq)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= IDLE;
         n_reg    <= '0;
         m_reg    <= '0;
         a0       <= '0;
         a1       <= '0;
         error_q  <= 1'b0;
         result_q <= '0;
      end else begin
         state <= next_state;
         unique case (state)
            IDLE: begin
               if (start) begin
                  n_reg   <= n_in;
                  m_reg   <= M_INIT;
                  error_q <= (n_in == '0);
               end
            end
            LOAD: begin
               a0 <= n_reg;
               a1 <= m_reg;
            end
            SUB: begin
               a0 <= a0_nxt;
               a1 <= a1_nxt;
            end
            CHECK: begin
               if (a0 == ONE) begin
                  result_q <= m_reg;
               end else begin
                  m_reg <= m_reg + ONE;
                  // Candidate space exhausted: no coprime m fits in WIDTH bits
                  if (m_reg == '1)
                     error_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (start)
               next_state = (n_in == '0) ? ERR : LOAD;
         end
         LOAD:  next_state = SUB;
         SUB:   next_state = eq ? CHECK : SUB;
         CHECK: begin
            if (a0 == ONE)
               next_state = DONE;
            else if (m_reg == '1)
               next_state = ERR;
            else
               next_state = LOAD;
         end
         DONE:    next_state = IDLE;
         ERR:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      busy   = (state != IDLE);
      done   = (state == DONE);
      error  = error_q;
      result = result_q;
   end

`ifdef RELPRIME_CYCLE_COUNT_EN
   logic [31:0] cyc_q;

   always_ff @(posedge CLK) begin
      if (RST)
         cyc_q <= '0;
      else if (state == IDLE && start)
         cyc_q <= '0;
      else if (state != IDLE && cyc_q != '1)
         cyc_q <= cyc_q + 32'd1;
   end

   assign cycles = cyc_q;
`endif

endmodule

// File: tb/tb_relprime_ctrl_seq.sv
// Directed bench for relprime_ctrl_seq: a WIDTH=16 and a WIDTH=4 instance.
// Also checks the cycle counter when RELPRIME_CYCLE_COUNT_EN is defined.
module tb_relprime_ctrl_seq;

   logic        clk = 1'b0;
   logic        rst16, start16;
   logic [15:0] n16;
   logic        busy16, done16, error16;
   logic [15:0] result16;
   logic        rst4, start4;
   logic [3:0]  n4;
   logic        busy4, done4, error4;
   logic [3:0]  result4;
   int          pass_cnt = 0;
   int          total_cnt = 0;

`ifdef RELPRIME_CYCLE_COUNT_EN
   logic [31:0] cycles16, cycles4;
`endif

   always #5 clk = ~clk;

   relprime_ctrl_seq #(.WIDTH(16), .M_START(2)) dut16 (
      .CLK    (clk),
      .RST    (rst16),
      .start  (start16),
      .n_in   (n16),
      .busy   (busy16),
      .done   (done16),
      .error  (error16),
      .result (result16)
`ifdef RELPRIME_CYCLE_COUNT_EN
      ,
      .cycles (cycles16)
`endif
   );

   relprime_ctrl_seq #(.WIDTH(4), .M_START(2)) dut4 (
      .CLK    (clk),
      .RST    (rst4),
      .start  (start4),
      .n_in   (n4),
      .busy   (busy4),
      .done   (done4),
      .error  (error4),
      .result (result4)
`ifdef RELPRIME_CYCLE_COUNT_EN
      ,
      .cycles (cycles4)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic go16(input logic [15:0] n);
      start16 = 1'b1;
      n16     = n;
      step();
      start16 = 1'b0;
   endtask

   task automatic go4(input logic [3:0] n);
      start4 = 1'b1;
      n4     = n;
      step();
      start4 = 1'b0;
   endtask

   task automatic wait_done16(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         if (done16) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      rst16 = 1'b1;
      rst4  = 1'b1;
      repeat (3) step();
      rst16 = 1'b0;
      rst4  = 1'b0;
      step();
      total_cnt++;
      if ({busy16, done16, error16} !== 3'b000)
         $display("FAIL reset16_flags got=%b want=000", {busy16, done16, error16});
      else pass_cnt++;
      total_cnt++;
      if (result16 !== 16'd0)
         $display("FAIL reset16_result got=%0d want=0", result16);
      else pass_cnt++;
      total_cnt++;
      if ({busy4, done4, error4} !== 3'b000)
         $display("FAIL reset4_flags got=%b want=000", {busy4, done4, error4});
      else pass_cnt++;
      total_cnt++;
      if (result4 !== 4'd0)
         $display("FAIL reset4_result got=%0d want=0", result4);
      else pass_cnt++;
   endtask

   task automatic test_n10();
      bit ok;
      go16(16'd10);
      wait_done16(500, ok);
      total_cnt++;
      if (!ok) $display("FAIL n10_timeout got=no_done want=done");
      else pass_cnt++;
      total_cnt++;
      if (result16 !== 16'd3)
         $display("FAIL n10_result got=%0d want=3", result16);
      else pass_cnt++;
      step();
      total_cnt++;
      if ({busy16, done16} !== 2'b00)
         $display("FAIL n10_after_done got=%b want=00", {busy16, done16});
      else pass_cnt++;
   endtask

   task automatic test_n1_latency();
      go16(16'd1);
      for (int e = 2; e <= 4; e++) begin
         step();
         total_cnt++;
         if (done16 !== 1'b0)
            $display("FAIL n1_early_done edge=%0d got=%b want=0", e, done16);
         else pass_cnt++;
      end
      step();
      total_cnt++;
      if (done16 !== 1'b1)
         $display("FAIL n1_done_edge5 got=%b want=1", done16);
      else pass_cnt++;
      total_cnt++;
      if (result16 !== 16'd2)
         $display("FAIL n1_result got=%0d want=2", result16);
      else pass_cnt++;
      step();
   endtask

   task automatic test_n30_ignore_start();
      bit ok;
      go16(16'd30);
      repeat (5) step();
      go16(16'd1);
      total_cnt++;
      if (busy16 !== 1'b1)
         $display("FAIL n30_busy_mid got=%b want=1", busy16);
      else pass_cnt++;
      wait_done16(1000, ok);
      total_cnt++;
      if (!ok) $display("FAIL n30_timeout got=no_done want=done");
      else pass_cnt++;
      total_cnt++;
      if (result16 !== 16'd7)
         $display("FAIL n30_result got=%0d want=7", result16);
      else pass_cnt++;
      step();
   endtask

   task automatic test_err();
      bit ok;
      go16(16'd0);
      total_cnt++;
      if ({error16, busy16} !== 2'b11)
         $display("FAIL err_state got=%b want=11", {error16, busy16});
      else pass_cnt++;
      step();
      total_cnt++;
      if ({error16, busy16, done16} !== 3'b100)
         $display("FAIL err_idle got=%b want=100", {error16, busy16, done16});
      else pass_cnt++;
      repeat (3) step();
      total_cnt++;
      if (error16 !== 1'b1)
         $display("FAIL err_sticky got=%b want=1", error16);
      else pass_cnt++;
      go16(16'd9);
      total_cnt++;
      if (error16 !== 1'b0)
         $display("FAIL err_clear got=%b want=0", error16);
      else pass_cnt++;
      wait_done16(500, ok);
      total_cnt++;
      if (!ok || result16 !== 16'd2)
         $display("FAIL n9_result got=%0d ok=%0d want=2", result16, ok);
      else pass_cnt++;
      step();
   endtask

   task automatic test_w4_abort();
      int  busy_cnt;
      bit  ok;
      int  dones;
      go4(4'd15);
      step();
      total_cnt++;
      if (busy4 !== 1'b1)
         $display("FAIL w4_busy_sub got=%b want=1", busy4);
      else pass_cnt++;
      rst4 = 1'b1;
      step();
      rst4 = 1'b0;
      total_cnt++;
      if ({busy4, done4} !== 2'b00)
         $display("FAIL w4_abort got=%b want=00", {busy4, done4});
      else pass_cnt++;
      dones = 0;
      repeat (4) begin
         step();
         if (done4) dones++;
      end
      total_cnt++;
      if (dones !== 0)
         $display("FAIL w4_no_done got=%0d want=0", dones);
      else pass_cnt++;
      go4(4'd15);
      busy_cnt = 0;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (busy4) busy_cnt++;
         if (done4) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      total_cnt++;
      if (!ok || result4 !== 4'd2)
         $display("FAIL w4_result got=%0d ok=%0d want=2", result4, ok);
      else pass_cnt++;
      total_cnt++;
      if (busy_cnt !== 12)
         $display("FAIL w4_busy_cycles got=%0d want=12", busy_cnt);
      else pass_cnt++;
      step();
`ifdef RELPRIME_CYCLE_COUNT_EN
      total_cnt++;
      if (cycles4 !== 32'(busy_cnt))
         $display("FAIL w4_cycles got=%0d want=%0d", cycles4, busy_cnt);
      else pass_cnt++;
`endif
   endtask

   initial begin
      rst16   = 1'b1;
      rst4    = 1'b1;
      start16 = 1'b0;
      start4  = 1'b0;
      n16     = '0;
      n4      = '0;
      test_reset();
      test_n10();
      test_n1_latency();
      test_n30_ignore_start();
      test_err();
      test_w4_abort();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
